// File: rtl/wb_pkg.sv
// Shared types and defaults for the multi-lane writeback stage.
//   wb_kind_e  : retire action of one EX/WB record
//   wb_rec_t   : one pre-decoded record (kind, dst, dst_vld, ext_vld, result, ext_result)
//   wb_state_e : writeback sequencing state
//   wb_is_store: true for kinds that must wait for the memory stage to commit
package wb_pkg;

  localparam int WB_XLEN       = 64;
  localparam int WB_NUM_REGS   = 16;
  localparam int WB_REG_W      = $clog2(WB_NUM_REGS);
  localparam int WB_RAX_IDX    = 0;
  localparam int WB_RDX_IDX    = 2;
  localparam int WB_RSP_IDX    = 4;
  localparam int WB_STACK_STEP = 8;

  typedef enum logic [3:0] {
    WB_NONE       = 4'd0,
    WB_REG        = 4'd1,
    WB_REG_EXT    = 4'd2,
    WB_SYS        = 4'd3,
    WB_RSP_DEC_ST = 4'd4,
    WB_STORE      = 4'd5,
    WB_RSP_INC    = 4'd6,
    WB_POP        = 4'd7,
    WB_HALT       = 4'd8
  } wb_kind_e;

  typedef struct packed {
    wb_kind_e              kind;
    logic [WB_REG_W-1:0]   dst;
    logic                  dst_vld;
    logic                  ext_vld;
    logic [WB_XLEN-1:0]    result;
    logic [WB_XLEN-1:0]    ext_result;
  } wb_rec_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } wb_state_e;

  function automatic logic wb_is_store(input wb_kind_e kind);
    return (kind == WB_RSP_DEC_ST) || (kind == WB_STORE);
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write scoreboard.
//   iss_*     : decode reservation request (iss_reg, plus iss_reg2 when iss_reg2_vld)
//   dec_vld/dec_idx : one decrement request per slot, already gated by the commit
//   iss_ready : low when a requested counter cannot absorb its increments
//   reg_busy  : counter != 0 per register
//   underflow : a decrement hit a zero counter this cycle (counter clamps at 0)
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int NUM_REGS = WB_NUM_REGS,
  parameter int SB_CNT_W = 2,
  parameter int NDEC     = 4,
  parameter int REG_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iss_valid,
  input  logic [REG_W-1:0]    iss_reg,
  input  logic                iss_reg2_vld,
  input  logic [REG_W-1:0]    iss_reg2,
  input  logic [NDEC-1:0]     dec_vld,
  input  logic [REG_W-1:0]    dec_idx [NDEC],
  output logic                iss_ready,
  output logic [NUM_REGS-1:0] reg_busy,
  output logic                underflow
);

  localparam int CNT_MAX = (1 << SB_CNT_W) - 1;

  logic [SB_CNT_W-1:0] cnt_r   [NUM_REGS];
  logic [SB_CNT_W-1:0] cnt_nxt_s [NUM_REGS];
  int                  req_s   [NUM_REGS];
  logic                ready_s;
  logic                uf_s;

  // Requested increments per register and readiness; duplicates count per occurrence.
  always_comb begin
    ready_s = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      req_s[r] = int'(iss_reg == REG_W'(r)) + int'(iss_reg2_vld && (iss_reg2 == REG_W'(r)));
      if (int'(cnt_r[r]) + req_s[r] > CNT_MAX) begin
        ready_s = 1'b0;
      end else begin
        ready_s = ready_s;
      end
    end
  end

  // Net increments against committed decrements; a decrement past zero clamps and flags.
  always_comb begin
    uf_s = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      int inc_v;
      int dec_v;
      int sum_v;
      inc_v = (iss_valid && ready_s) ? req_s[r] : 0;
      dec_v = 0;
      for (int d = 0; d < NDEC; d++) begin
        dec_v = dec_v + int'(dec_vld[d] && (dec_idx[d] == REG_W'(r)));
      end
      sum_v = int'(cnt_r[r]) + inc_v;
      if (dec_v > sum_v) begin
        cnt_nxt_s[r] = '0;
        uf_s         = 1'b1;
      end else begin
        cnt_nxt_s[r] = SB_CNT_W'(sum_v - dec_v);
      end
    end
  end

  // Busy view for decode.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      reg_busy[r] = (cnt_r[r] != '0);
    end
  end

  assign iss_ready = ready_s;
  assign underflow = uf_s;

  // Counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= '0;
      end
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/mod_writeback_multi.sv
// Multi-lane writeback stage: retires up to NUM_CH records per cycle into the register file.
//   wb_valid/wb_rec/wb_ready : retire bundle handshake (lane 0 oldest)
//   st_req/st_ack            : store bundle parked until the memory stage commits it
//   iss_*/iss_ready/reg_busy : pending-write scoreboard interface to decode
//   regfile                  : architectural state, updated one cycle after commit
//   halted/proto_err         : sticky status
module mod_writeback_multi
  import wb_pkg::*;
#(
  parameter int              XLEN       = WB_XLEN,
  parameter int              NUM_REGS   = WB_NUM_REGS,
  parameter int              NUM_CH     = 2,
  parameter int              SB_CNT_W   = 2,
  parameter int              RSP_IDX    = WB_RSP_IDX,
  parameter int              RDX_IDX    = WB_RDX_IDX,
  parameter int              STACK_STEP = WB_STACK_STEP,
  parameter logic [XLEN-1:0] RSP_RESET  = '0,
  parameter int              REG_W      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   wb_valid,
  input  wb_rec_t             wb_rec [NUM_CH],
  output logic                wb_ready,
  output logic                st_req,
  input  logic                st_ack,
  input  logic                iss_valid,
  input  logic [REG_W-1:0]    iss_reg,
  input  logic                iss_reg2_vld,
  input  logic [REG_W-1:0]    iss_reg2,
  output logic                iss_ready,
  output logic [NUM_REGS-1:0] reg_busy,
  output logic [XLEN-1:0]     regfile [NUM_REGS],
  output logic                halted,
  output logic                proto_err
);

  localparam int NDEC = 2 * NUM_CH;

  wb_state_e          state_r;
  logic [NUM_CH-1:0]  hold_valid_r;
  wb_rec_t            hold_rec_r [NUM_CH];

  logic [NUM_CH-1:0]  src_valid_s;
  wb_rec_t            src_rec_s [NUM_CH];
  logic               accept_s;
  logic               lane0_store_s;
  logic               commit_s;
  logic [XLEN-1:0]    fold_rf_s [NUM_REGS];
  logic               fold_halt_s;
  logic               fold_proto_s;
  logic [NDEC-1:0]    dec_vld_s;
  logic [REG_W-1:0]   dec_idx_s [NDEC];
  logic               sb_uf_s;

  // The parked bundle replaces the live inputs while waiting for the store commit.
  always_comb begin
    if (state_r == ST_WAIT) begin
      src_valid_s = hold_valid_r;
      src_rec_s   = hold_rec_r;
    end else begin
      src_valid_s = wb_valid;
      src_rec_s   = wb_rec;
    end
  end

  assign accept_s      = (state_r == ST_RUN) && (|wb_valid);
  assign lane0_store_s = wb_valid[0] && wb_is_store(wb_rec[0].kind);
  assign commit_s      = (accept_s && !lane0_store_s) || ((state_r == ST_WAIT) && st_ack);

  // Fold lanes oldest-first on a working copy, so later writes and RSP steps stack naturally.
  always_comb begin
    fold_rf_s    = regfile;
    fold_halt_s  = 1'b0;
    fold_proto_s = 1'b0;
    dec_vld_s    = '0;
    for (int d = 0; d < NDEC; d++) begin
      dec_idx_s[d] = '0;
    end
    for (int l = 0; l < NUM_CH; l++) begin
      if (src_valid_s[l] && !fold_halt_s) begin
        case (src_rec_s[l].kind)
          WB_REG, WB_REG_EXT: begin
            fold_rf_s[src_rec_s[l].dst] = src_rec_s[l].result;
            dec_vld_s[2*l]              = src_rec_s[l].dst_vld;
            dec_idx_s[2*l]              = src_rec_s[l].dst;
            if ((src_rec_s[l].kind == WB_REG_EXT) && src_rec_s[l].ext_vld) begin
              fold_rf_s[RDX_IDX] = src_rec_s[l].ext_result;
              dec_vld_s[2*l+1]   = 1'b1;
              dec_idx_s[2*l+1]   = REG_W'(RDX_IDX);
            end else begin
              dec_vld_s[2*l+1]   = 1'b0;
            end
          end
          WB_SYS: begin
            fold_rf_s[WB_RAX_IDX] = src_rec_s[l].result;
            dec_vld_s[2*l]        = src_rec_s[l].dst_vld;
            dec_idx_s[2*l]        = REG_W'(WB_RAX_IDX);
          end
          WB_RSP_DEC_ST: begin
            // Only lane 0 can be a store; elsewhere it is dropped and flagged.
            if (l == 0) begin
              fold_rf_s[RSP_IDX] = fold_rf_s[RSP_IDX] - XLEN'(STACK_STEP);
            end else begin
              fold_proto_s = 1'b1;
            end
          end
          WB_STORE: begin
            fold_proto_s = fold_proto_s | (l != 0);
          end
          WB_RSP_INC: begin
            fold_rf_s[RSP_IDX] = fold_rf_s[RSP_IDX] + XLEN'(STACK_STEP);
          end
          WB_POP: begin
            fold_rf_s[RSP_IDX]          = fold_rf_s[RSP_IDX] + XLEN'(STACK_STEP);
            fold_rf_s[src_rec_s[l].dst] = src_rec_s[l].result;
            dec_vld_s[2*l]              = src_rec_s[l].dst_vld;
            dec_idx_s[2*l]              = src_rec_s[l].dst;
          end
          WB_HALT: begin
            fold_halt_s = 1'b1;
          end
          default: begin
            fold_halt_s = fold_halt_s;
          end
        endcase
      end else begin
        // Invalid lane, or a lane at/after HALT: no effect.
        fold_halt_s = fold_halt_s;
      end
    end
  end

  wb_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .SB_CNT_W (SB_CNT_W),
    .NDEC     (NDEC),
    .REG_W    (REG_W)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .iss_valid    (iss_valid),
    .iss_reg      (iss_reg),
    .iss_reg2_vld (iss_reg2_vld),
    .iss_reg2     (iss_reg2),
    .dec_vld      (dec_vld_s & {NDEC{commit_s}}),
    .dec_idx      (dec_idx_s),
    .iss_ready    (iss_ready),
    .reg_busy     (reg_busy),
    .underflow    (sb_uf_s)
  );

  // Sequencing FSM with registered handshake/status outputs and the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_RUN;
      wb_ready     <= 1'b1;
      st_req       <= 1'b0;
      halted       <= 1'b0;
      proto_err    <= 1'b0;
      hold_valid_r <= '0;
      for (int l = 0; l < NUM_CH; l++) begin
        hold_rec_r[l] <= '0;
      end
      for (int r = 0; r < NUM_REGS; r++) begin
        regfile[r] <= (r == RSP_IDX) ? RSP_RESET : '0;
      end
    end else begin
      proto_err <= proto_err | sb_uf_s | (commit_s & fold_proto_s);
      if (commit_s) begin
        regfile <= fold_rf_s;
      end
      case (state_r)
        ST_RUN: begin
          if (accept_s && lane0_store_s) begin
            hold_valid_r <= wb_valid;
            hold_rec_r   <= wb_rec;
            state_r      <= ST_WAIT;
            st_req       <= 1'b1;
            wb_ready     <= 1'b0;
          end else if (commit_s && fold_halt_s) begin
            state_r  <= ST_HALTED;
            halted   <= 1'b1;
            wb_ready <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (st_ack) begin
            st_req <= 1'b0;
            if (fold_halt_s) begin
              state_r <= ST_HALTED;
              halted  <= 1'b1;
            end else begin
              state_r  <= ST_RUN;
              wb_ready <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          wb_ready <= 1'b0;
        end
        default: begin
          state_r  <= ST_RUN;
          wb_ready <= 1'b1;
          st_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_writeback_multi.sv
// Self-checking bench for mod_writeback_multi: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the retire rules.
module tb_mod_writeback_multi;
  import wb_pkg::*;

  localparam int NCH     = 2;
  localparam int NREG    = 16;
  localparam int CNT_MAX = 3;
  localparam int RSP     = 4;
  localparam int RDX     = 2;
  localparam int STEP    = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  wb_valid;
  wb_rec_t         wb_rec [NCH];
  logic            wb_ready;
  logic            st_req;
  logic            st_ack;
  logic            iss_valid;
  logic [3:0]      iss_reg;
  logic            iss_reg2_vld;
  logic [3:0]      iss_reg2;
  logic            iss_ready;
  logic [NREG-1:0] reg_busy;
  logic [63:0]     regfile [NREG];
  logic            halted;
  logic            proto_err;

  always #5 clk = ~clk;

  mod_writeback_multi #(.NUM_CH(NCH), .SB_CNT_W(2)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_rec(wb_rec), .wb_ready(wb_ready),
    .st_req(st_req), .st_ack(st_ack), .iss_valid(iss_valid), .iss_reg(iss_reg),
    .iss_reg2_vld(iss_reg2_vld), .iss_reg2(iss_reg2), .iss_ready(iss_ready),
    .reg_busy(reg_busy), .regfile(regfile), .halted(halted), .proto_err(proto_err)
  );

  // Reference model state: 0 = accepting, 1 = waiting for store ack, 2 = halted.
  logic [63:0] m_rf [NREG];
  int          m_cnt [NREG];
  int          m_dec [NREG];
  int          m_st;
  bit          m_proto;
  logic [1:0]  m_hold_v;
  wb_rec_t     m_hold [NCH];
  logic [1:0]  c_v;
  wb_rec_t     c_rec [NCH];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic wb_rec_t mk(input wb_kind_e k, input int dst, input bit dv, input bit ev,
                                 input logic [63:0] res, input logic [63:0] ext);
    wb_rec_t r;
    r.kind = k; r.dst = 4'(dst); r.dst_vld = dv; r.ext_vld = ev;
    r.result = res; r.ext_result = ext;
    return r;
  endfunction

  function automatic bit m_iss_ready();
    for (int r = 0; r < NREG; r++) begin
      int req;
      req = int'(iss_reg == 4'(r)) + int'(iss_reg2_vld && iss_reg2 == 4'(r));
      if (m_cnt[r] + req > CNT_MAX) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_rf[r] = 64'd0;
      m_cnt[r] = 0;
    end
    m_st = 0;
    m_proto = 1'b0;
  endtask

  // Retire a bundle in program order: later writes win, RSP steps apply to current RSP.
  task automatic m_commit();
    bit stop;
    stop = 1'b0;
    for (int l = 0; l < NCH; l++) begin
      if (c_v[l] && !stop) begin
        case (c_rec[l].kind)
          WB_REG: begin
            m_rf[c_rec[l].dst] = c_rec[l].result;
            if (c_rec[l].dst_vld) m_dec[c_rec[l].dst]++;
          end
          WB_REG_EXT: begin
            m_rf[c_rec[l].dst] = c_rec[l].result;
            if (c_rec[l].dst_vld) m_dec[c_rec[l].dst]++;
            if (c_rec[l].ext_vld) begin
              m_rf[RDX] = c_rec[l].ext_result;
              m_dec[RDX]++;
            end
          end
          WB_SYS: begin
            m_rf[0] = c_rec[l].result;
            if (c_rec[l].dst_vld) m_dec[0]++;
          end
          WB_RSP_DEC_ST: if (l == 0) m_rf[RSP] = m_rf[RSP] - 64'(STEP); else m_proto = 1'b1;
          WB_STORE:      if (l != 0) m_proto = 1'b1;
          WB_RSP_INC:    m_rf[RSP] = m_rf[RSP] + 64'(STEP);
          WB_POP: begin
            m_rf[RSP] = m_rf[RSP] + 64'(STEP);
            m_rf[c_rec[l].dst] = c_rec[l].result;
            if (c_rec[l].dst_vld) m_dec[c_rec[l].dst]++;
          end
          WB_HALT: stop = 1'b1;
          default: ;
        endcase
      end
    end
    m_st = stop ? 2 : 0;
  endtask

  task automatic model_edge();
    int  inc [NREG];
    bit  rdy;
    rdy = m_iss_ready();
    for (int r = 0; r < NREG; r++) begin
      inc[r] = 0;
      m_dec[r] = 0;
    end
    if (iss_valid && rdy) begin
      inc[iss_reg]++;
      if (iss_reg2_vld) inc[iss_reg2]++;
    end
    if (m_st == 0 && wb_valid != 2'b00) begin
      if (wb_valid[0] && (wb_rec[0].kind == WB_RSP_DEC_ST || wb_rec[0].kind == WB_STORE)) begin
        m_hold_v = wb_valid;
        m_hold = wb_rec;
        m_st = 1;
      end else begin
        c_v = wb_valid;
        c_rec = wb_rec;
        m_commit();
      end
    end else if (m_st == 1 && st_ack) begin
      c_v = m_hold_v;
      c_rec = m_hold;
      m_commit();
    end
    for (int r = 0; r < NREG; r++) begin
      int n;
      n = m_cnt[r] + inc[r] - m_dec[r];
      if (n < 0) begin
        n = 0;
        m_proto = 1'b1;
      end
      m_cnt[r] = n;
    end
  endtask

  task automatic compare_all();
    logic [NREG-1:0] busy;
    for (int r = 0; r < NREG; r++) begin
      chk($sformatf("rf%0d", r), regfile[r], m_rf[r]);
      busy[r] = (m_cnt[r] != 0);
    end
    chk("reg_busy", 64'(reg_busy), 64'(busy));
    chk("st_req", 64'(st_req), 64'(m_st == 1));
    chk("wb_ready", 64'(wb_ready), 64'(m_st == 0));
    chk("halted", 64'(halted), 64'(m_st == 2));
    chk("proto_err", 64'(proto_err), 64'(m_proto));
  endtask

  // One clock: check iss_ready before the edge, advance model, compare after the edge.
  task automatic step();
    #1;
    chk("iss_ready", 64'(iss_ready), 64'(m_iss_ready()));
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle();
    wb_valid = 2'b00;
    st_ack = 1'b0;
    iss_valid = 1'b0;
    iss_reg = 4'd0;
    iss_reg2_vld = 1'b0;
    iss_reg2 = 4'd0;
    for (int l = 0; l < NCH; l++) wb_rec[l] = mk(WB_NONE, 0, 1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  function automatic wb_rec_t rand_rec();
    int p;
    wb_kind_e k;
    p = $urandom_range(0, 99);
    if (p < 10)      k = WB_NONE;
    else if (p < 35) k = WB_REG;
    else if (p < 45) k = WB_REG_EXT;
    else if (p < 50) k = WB_SYS;
    else if (p < 60) k = WB_RSP_DEC_ST;
    else if (p < 66) k = WB_STORE;
    else if (p < 75) k = WB_RSP_INC;
    else if (p < 98) k = WB_POP;
    else             k = WB_HALT;
    return mk(k, $urandom_range(0, 15),
              (k == WB_REG || k == WB_REG_EXT || k == WB_POP || k == WB_SYS) && ($urandom_range(0, 2) == 0),
              $urandom_range(0, 1) == 1, {$urandom, $urandom}, {$urandom, $urandom});
  endfunction

  initial begin
    int hc;
    idle();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    compare_all();
    chk("rst_rsp", regfile[RSP], 64'd0);
    reset = 1'b0;

    // Same-register write in both lanes: lane 1 wins.
    wb_valid = 2'b11;
    wb_rec[0] = mk(WB_REG, 3, 1'b0, 1'b0, 64'hAA, 64'd0);
    wb_rec[1] = mk(WB_REG, 3, 1'b0, 1'b0, 64'hBB, 64'd0);
    step();
    chk("lane_order_r3", regfile[3], 64'hBB);

    // PUSH waits three cycles for the store ack before RSP moves.
    idle();
    wb_valid = 2'b01;
    wb_rec[0] = mk(WB_REG, RSP, 1'b0, 1'b0, 64'h1000, 64'd0);
    step();
    wb_rec[0] = mk(WB_RSP_DEC_ST, 0, 1'b0, 1'b0, 64'd0, 64'd0);
    step();
    chk("push_streq", 64'(st_req), 64'd1);
    chk("push_rsp_held", regfile[RSP], 64'h1000);
    idle();
    step();
    step();
    chk("push_wait_ready", 64'(wb_ready), 64'd0);
    chk("push_rsp_wait", regfile[RSP], 64'h1000);
    st_ack = 1'b1;
    step();
    chk("push_rsp_done", regfile[RSP], 64'hFF8);
    chk("push_streq_clr", 64'(st_req), 64'd0);

    // POP then RET in the same bundle.
    idle();
    wb_valid = 2'b01;
    wb_rec[0] = mk(WB_REG, RSP, 1'b0, 1'b0, 64'h100, 64'd0);
    step();
    wb_valid = 2'b11;
    wb_rec[0] = mk(WB_POP, 5, 1'b0, 1'b0, 64'd7, 64'd0);
    wb_rec[1] = mk(WB_RSP_INC, 0, 1'b0, 1'b0, 64'd0, 64'd0);
    step();
    chk("pop_ret_rsp", regfile[RSP], 64'h110);
    chk("pop_r5", regfile[5], 64'd7);

    // IMUL with high half: both reservations released at the commit edge.
    idle();
    iss_valid = 1'b1; iss_reg = 4'd0; iss_reg2_vld = 1'b1; iss_reg2 = 4'd2;
    step();
    chk("imul_busy", 64'(reg_busy & 16'h0005), 64'h5);
    idle();
    wb_valid = 2'b01;
    wb_rec[0] = mk(WB_REG_EXT, 0, 1'b1, 1'b1, 64'h55, 64'h1);
    step();
    chk("imul_r0", regfile[0], 64'h55);
    chk("imul_r2", regfile[2], 64'h1);
    chk("imul_busy_clr", 64'(reg_busy & 16'h0005), 64'h0);

    // Counter saturation on r7.
    idle();
    iss_valid = 1'b1; iss_reg = 4'd7;
    repeat (3) step();
    #1;
    chk("r7_saturated", 64'(iss_ready), 64'd0);
    step();
    idle();
    wb_valid = 2'b01;
    wb_rec[0] = mk(WB_REG, 7, 1'b1, 1'b0, 64'h77, 64'd0);
    step();
    idle();
    iss_valid = 1'b1; iss_reg = 4'd7;
    #1;
    chk("r7_ready_again", 64'(iss_ready), 64'd1);
    step();

    // Reset while a PUSH is parked: bundle is discarded.
    idle();
    wb_valid = 2'b01;
    wb_rec[0] = mk(WB_RSP_DEC_ST, 0, 1'b0, 1'b0, 64'd0, 64'd0);
    step();
    chk("park_streq", 64'(st_req), 64'd1);
    idle();
    do_reset();
    chk("rst_wait_streq", 64'(st_req), 64'd0);
    st_ack = 1'b1;
    step();
    step();
    chk("rst_wait_rsp", regfile[RSP], 64'd0);

    // Randomized traffic.
    hc = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      wb_valid = 2'($urandom_range(0, 3));
      for (int l = 0; l < NCH; l++) wb_rec[l] = rand_rec();
      st_ack = ($urandom_range(0, 2) == 0);
      iss_valid = $urandom_range(0, 1) == 1;
      iss_reg = 4'($urandom_range(0, 15));
      iss_reg2_vld = $urandom_range(0, 1) == 1;
      iss_reg2 = ($urandom_range(0, 3) == 0) ? iss_reg : 4'($urandom_range(0, 15));
      step();
      if (m_st == 2) hc++;
      if (hc > 6 || $urandom_range(0, 299) == 0) begin
        do_reset();
        hc = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
